uart_receiver: RTL and testbench

- Serial-to-parallel UART receiver; the receive-side counterpart of the project's UART transmitter.
- Frame format: 1 start bit (0), 8 data bits MSB first, 1 stop bit (1); no parity; line idles high.
- Presents each received byte on DATA with a one-cycle Rdy strobe. Its outputs can drive the transmitter's DATA/Rdy inputs directly for loopback.
- Sits between the board RX pin and the MEMS/SPI command logic.

---
 rtl/uart_receiver_pkg.sv | 23 ++
 rtl/uart_receiver_sync_2ff.sv | 29 ++
 rtl/uart_receiver.sv | 118 +++++++++++
 tb/tb_uart_receiver.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_receiver_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : uart_pkg                                                 |
// | Shared UART frame constants, bit-period default and receiver states.|
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
package uart_pkg;

  localparam int DEF_CLKS_PER_BIT = 174;
  localparam int DATA_BITS        = 8;
  localparam logic START_LVL      = 1'b0;
  localparam logic STOP_LVL       = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_receiver_sync_2ff.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : sync_2ff                                                 |
// | Two-flop synchroniser for asynchronous single-bit inputs.          |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_meta <= RST_VAL;
      o_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : uart_receiver                                            |
// | 8N1 UART receiver, MSB first, single mid-bit sample per bit.       |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int SAMPLE_POINT = CLKS_PER_BIT / 2
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       RX,
  output logic [7:0] DATA,
  output logic       Rdy,
  output logic       FERR,
  output logic       BUSY
);

  localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX    = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_SAMPLE = c_CNT_W'(SAMPLE_POINT);
  localparam logic [2:0]         c_IDX_LAST   = 3'(DATA_BITS - 1);

  logic               w_rx_s;
  rx_state_t          r_state;
  logic [c_CNT_W-1:0] r_bit_cnt;
  logic [2:0]         r_idx;
  logic [7:0]         r_shifter;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .CLK  (CLK),
    .RSTn (RSTn),
    .i_d  (RX),
    .o_q  (w_rx_s)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_idx     <= '0;
      r_shifter <= '0;
      DATA      <= 8'h00;
      Rdy       <= 1'b0;
      FERR      <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      Rdy  <= 1'b0;
      FERR <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rx_s == START_LVL) begin
            r_state   <= ST_START;
            r_bit_cnt <= '0;
            BUSY      <= 1'b1;
          end
        end
        ST_START: begin
          if (r_bit_cnt == c_CNT_SAMPLE) begin
            r_bit_cnt <= '0;
            if (w_rx_s == START_LVL) begin
              r_state <= ST_DATA;
              r_idx   <= '0;
            end else begin
              // Start bit vanished by mid-bit: treat as a line glitch.
              r_state <= ST_IDLE;
              BUSY    <= 1'b0;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_bit_cnt == c_CNT_MAX) begin
            r_bit_cnt <= '0;
            r_shifter <= {r_shifter[6:0], w_rx_s};
            if (r_idx == c_IDX_LAST) r_state <= ST_STOP;
            else                     r_idx   <= r_idx + 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (r_bit_cnt == c_CNT_MAX) begin
            r_bit_cnt <= '0;
            if (w_rx_s == STOP_LVL) begin
              DATA    <= r_shifter;
              Rdy     <= 1'b1;
              r_state <= ST_IDLE;
              BUSY    <= 1'b0;
            end else begin
              FERR    <= 1'b1;
              r_state <= ST_WAIT_HIGH;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        ST_WAIT_HIGH: begin
          // A held-low line is a break, not a new start bit.
          if (w_rx_s == STOP_LVL) begin
            r_state <= ST_IDLE;
            BUSY    <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_uart_receiver                                         |
// | Self-checking bench for uart_receiver against a frame-level model. |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int CPB     = DEF_CLKS_PER_BIT;
  localparam int SP      = CPB / 2;
  localparam int LATENCY = 2 + SP + 9 * CPB + 1;
  localparam int WAIT_LIMIT = 12 * CPB;

  logic       CLK  = 1'b0;
  logic       RSTn = 1'b0;
  logic       RX   = 1'b1;
  logic [7:0] DATA;
  logic       Rdy, FERR, BUSY;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_last = 8'h00;

  uart_receiver dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .RX   (RX),
    .DATA (DATA),
    .Rdy  (Rdy),
    .FERR (FERR),
    .BUSY (BUSY)
  );

  always #5 CLK = ~CLK;

  // Event recorder: every Rdy/FERR pulse seen on the outputs.
  int         cyc = 0;
  logic [7:0] rdy_q[$];
  int         rdy_cyc_q[$];
  int         ferr_cnt = 0, overlap_cnt = 0, double_cnt = 0, busy_rise = 0;
  logic       prev_rdy = 1'b0, prev_ferr = 1'b0, prev_busy = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (Rdy === 1'b1) begin
      rdy_q.push_back(DATA);
      rdy_cyc_q.push_back(cyc);
    end
    if (FERR === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (Rdy === 1'b1 && FERR === 1'b1) overlap_cnt <= overlap_cnt + 1;
    if ((Rdy === 1'b1 && prev_rdy) || (FERR === 1'b1 && prev_ferr)) double_cnt <= double_cnt + 1;
    if (BUSY === 1'b1 && !prev_busy) busy_rise <= busy_rise + 1;
    prev_rdy  <= (Rdy === 1'b1);
    prev_ferr <= (FERR === 1'b1);
    prev_busy <= (BUSY === 1'b1);
  end

  task automatic drive_bit(input logic v, input int n);
    RX = v;
    repeat (n) @(negedge CLK);
  endtask

  // stop_low == 0 sends a proper stop bit, otherwise the stop bit is held low that many bit periods.
  task automatic send_frame(input logic [7:0] b, input int stop_low);
    drive_bit(1'b0, CPB);
    for (int i = 7; i >= 0; i--) drive_bit(b[i], CPB);
    if (stop_low > 0) drive_bit(1'b0, stop_low * CPB);
    else              drive_bit(1'b1, CPB);
    RX = 1'b1;
  endtask

  task automatic wait_rdy(input int n);
    int t = 0;
    while (rdy_q.size() < n && t < WAIT_LIMIT) begin
      @(negedge CLK);
      t++;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (BUSY !== 1'b0 && t < WAIT_LIMIT) begin
      @(negedge CLK);
      t++;
    end
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({DATA, Rdy, FERR, BUSY} !== 11'h000) begin
      n_fail++;
      $display("FAIL reset_values: got DATA=%h Rdy=%b FERR=%b BUSY=%b, want 00/0/0/0", DATA, Rdy, FERR, BUSY);
    end
    RSTn = 1'b1;
    repeat (20) @(negedge CLK);
    n_checks++;
    if (BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_busy: got BUSY=%b, want 0", BUSY);
    end
  endtask

  task automatic test_single();
    int base = rdy_q.size();
    int fb   = ferr_cnt;
    int c0   = cyc;
    send_frame(8'hA5, 0);
    wait_rdy(base + 1);
    n_checks++;
    if (rdy_q.size() != base + 1) begin
      n_fail++;
      $display("FAIL single_count: got %0d Rdy pulses, want 1", rdy_q.size() - base);
    end else begin
      n_checks++;
      if (rdy_q[base] !== 8'hA5) begin
        n_fail++;
        $display("FAIL single_data: got %h, want a5", rdy_q[base]);
      end
      n_checks++;
      if (rdy_cyc_q[base] - (c0 + 1) != LATENCY) begin
        n_fail++;
        $display("FAIL single_latency: got %0d cycles, want %0d", rdy_cyc_q[base] - (c0 + 1), LATENCY);
      end
    end
    n_checks++;
    if (ferr_cnt != fb) begin
      n_fail++;
      $display("FAIL single_ferr: got %0d FERR pulses, want 0", ferr_cnt - fb);
    end
    exp_last = 8'hA5;
    wait_idle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[3] = '{8'h00, 8'hFF, 8'h3C};
    int base = rdy_q.size();
    int br   = busy_rise;
    for (int i = 0; i < 3; i++) send_frame(exp[i], 0);
    wait_rdy(base + 3);
    n_checks++;
    if (rdy_q.size() != base + 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d Rdy pulses, want 3", rdy_q.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (rdy_q[base + i] !== exp[i]) begin
          n_fail++;
          $display("FAIL b2b_data[%0d]: got %h, want %h", i, rdy_q[base + i], exp[i]);
        end
      end
    end
    n_checks++;
    if (busy_rise - br != 3) begin
      n_fail++;
      $display("FAIL b2b_busy_gaps: got %0d BUSY rises, want 3", busy_rise - br);
    end
    exp_last = 8'h3C;
    wait_idle();
  endtask

  task automatic test_glitch();
    int base = rdy_q.size();
    int fb   = ferr_cnt;
    drive_bit(1'b0, 40);
    drive_bit(1'b1, SP + 3 - 40);
    n_checks++;
    if (BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_busy_hold: got BUSY=%b before mid-start sample, want 1", BUSY);
    end
    @(negedge CLK);
    n_checks++;
    if (BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_busy_drop: got BUSY=%b after mid-start sample, want 0", BUSY);
    end
    repeat (2 * CPB) @(negedge CLK);
    n_checks++;
    if (rdy_q.size() != base || ferr_cnt != fb) begin
      n_fail++;
      $display("FAIL glitch_no_pulse: got Rdy=%0d FERR=%0d pulses, want 0/0", rdy_q.size() - base, ferr_cnt - fb);
    end
    send_frame(8'h5A, 0);
    wait_rdy(base + 1);
    n_checks++;
    if (rdy_q.size() != base + 1 || rdy_q[rdy_q.size() - 1] !== 8'h5A) begin
      n_fail++;
      $display("FAIL glitch_next_frame: got %0d pulses last=%h, want 1 pulse 5a", rdy_q.size() - base, DATA);
    end
    exp_last = 8'h5A;
    wait_idle();
  endtask

  task automatic test_framing();
    int base = rdy_q.size();
    int fb   = ferr_cnt;
    send_frame(8'h81, 3);
    n_checks++;
    if (BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL ferr_wait_high: got BUSY=%b while line low, want 1", BUSY);
    end
    n_checks++;
    if (ferr_cnt - fb != 1 || rdy_q.size() != base) begin
      n_fail++;
      $display("FAIL ferr_pulse: got FERR=%0d Rdy=%0d pulses, want 1/0", ferr_cnt - fb, rdy_q.size() - base);
    end
    n_checks++;
    if (DATA !== exp_last) begin
      n_fail++;
      $display("FAIL ferr_data_hold: got %h, want %h", DATA, exp_last);
    end
    wait_idle();
    send_frame(8'h42, 0);
    wait_rdy(base + 1);
    n_checks++;
    if (rdy_q.size() != base + 1 || DATA !== 8'h42) begin
      n_fail++;
      $display("FAIL ferr_recover: got %0d pulses DATA=%h, want 1 pulse 42", rdy_q.size() - base, DATA);
    end
    exp_last = 8'h42;
    wait_idle();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b = 8'hC3;
    int base;
    int fb;
    drive_bit(1'b0, CPB);
    for (int i = 7; i >= 4; i--) drive_bit(b[i], CPB);
    drive_bit(b[3], CPB / 2);
    #2 RSTn = 1'b0;
    #1;
    n_checks++;
    if ({DATA, Rdy, FERR, BUSY} !== 11'h000) begin
      n_fail++;
      $display("FAIL midreset_values: got DATA=%h Rdy=%b FERR=%b BUSY=%b, want 00/0/0/0", DATA, Rdy, FERR, BUSY);
    end
    RX = 1'b1;
    repeat (5) @(negedge CLK);
    RSTn = 1'b1;
    exp_last = 8'h00;
    base = rdy_q.size();
    fb   = ferr_cnt;
    repeat (10 * CPB) @(negedge CLK);
    n_checks++;
    if (rdy_q.size() != base || ferr_cnt != fb || DATA !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset_discard: got Rdy=%0d FERR=%0d DATA=%h, want 0/0/00", rdy_q.size() - base, ferr_cnt - fb, DATA);
    end
    send_frame(8'h99, 0);
    wait_rdy(base + 1);
    n_checks++;
    if (rdy_q.size() != base + 1 || DATA !== 8'h99) begin
      n_fail++;
      $display("FAIL midreset_next: got %0d pulses DATA=%h, want 1 pulse 99", rdy_q.size() - base, DATA);
    end
    exp_last = 8'h99;
    wait_idle();
  endtask

  // The bench plays the transmitter: each received byte is sent straight back on RX.
  task automatic test_loopback();
    int base = rdy_q.size();
    int fb   = ferr_cnt;
    send_frame(8'h5A, 0);
    for (int i = 0; i < 16; i++) begin
      wait_rdy(base + i + 1);
      n_checks++;
      if (rdy_q.size() < base + i + 1) begin
        n_fail++;
        $display("FAIL loopback_timeout[%0d]: got %0d bytes, want %0d", i, rdy_q.size() - base, i + 1);
        break;
      end
      if (rdy_q[base + i] !== 8'h5A) begin
        n_fail++;
        $display("FAIL loopback_data[%0d]: got %h, want 5a", i, rdy_q[base + i]);
      end
      if (i < 15) send_frame(rdy_q[base + i], 0);
    end
    n_checks++;
    if (ferr_cnt != fb) begin
      n_fail++;
      $display("FAIL loopback_ferr: got %0d FERR pulses, want 0", ferr_cnt - fb);
    end
    exp_last = 8'h5A;
    wait_idle();
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int exp_ferr = 0;
    int base = rdy_q.size();
    int fb   = ferr_cnt;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b   = 8'($urandom);
      bit         bad = ($urandom_range(0, 3) == 0);
      if (bad) exp_ferr++;
      else     exp_q.push_back(b);
      send_frame(b, bad ? 1 : 0);
      drive_bit(1'b1, bad ? CPB * (1 + $urandom_range(0, 1)) : CPB * $urandom_range(0, 1));
    end
    wait_idle();
    n_checks++;
    if (rdy_q.size() - base != exp_q.size() || ferr_cnt - fb != exp_ferr) begin
      n_fail++;
      $display("FAIL random_counts: got Rdy=%0d FERR=%0d, want %0d/%0d", rdy_q.size() - base, ferr_cnt - fb, exp_q.size(), exp_ferr);
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (rdy_q[base + i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random_data[%0d]: got %h, want %h", i, rdy_q[base + i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_pulse_rules();
    n_checks++;
    if (overlap_cnt != 0 || double_cnt != 0) begin
      n_fail++;
      $display("FAIL pulse_rules: got %0d overlaps and %0d multi-cycle pulses, want 0/0", overlap_cnt, double_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_mid_frame();
    test_loopback();
    test_random();
    test_pulse_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
